ecc_apb_driver: RTL and testbench
=================================

Name: ecc_apb_driver

Overview:
- APB initiator that sequences one ECC operation per command into the encoder/decoder register file.
- Takes a command (work type, data, noise, codeword width) over a valid/ready handshake.
- Issues APB writes, waits for operation_done, captures data_out and num_of_errors, and returns a one-cycle response.
- Sits between test sequencers (or a host FSM) and the ecc_enc_dec APB slave.

Parameters:
- AMBA_ADDR_WIDTH, 32, APB address width.
- AMBA_WORD, 32, APB data width.
- DATA_WIDTH, 32, data_in/data_out/noise width (DATA_WIDTH <= AMBA_WORD).
- TIMEOUT_CYCLES, 1024, maximum cycles waiting for operation_done.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver idle, command accepted when cmd_valid&&cmd_ready.
- cmd_type  in  2  0=nothing, 1=encode, 2=decode, 3=full channel.
- cmd_width  in  2  CODEWORD_WIDTH register value.
- cmd_data  in  DATA_WIDTH  DATA_IN value.
- cmd_noise  in  DATA_WIDTH  NOISE value.
- paddr  out  AMBA_ADDR_WIDTH  APB address.
- pwdata  out  AMBA_WORD  APB write data.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- prdata  in  AMBA_WORD  APB read data.
- operation_done  in  1  slave completion pulse.
- data_out  in  DATA_WIDTH  slave result.
- num_of_errors  in  2  slave error count.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_WIDTH  captured data_out.
- rsp_num_err  out  2  captured num_of_errors.
- rsp_timeout  out  1  set with rsp_valid if no operation_done was seen.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0, except cmd_ready=1.
  - FSM goes to IDLE; counters and captured command cleared.
- Register map (byte addresses): CTRL 0x00, DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C.
- CTRL value = cmd_type-1 (0 encode, 1 decode, 2 full channel), zero-extended to AMBA_WORD.
- pwdata for DATA_IN and NOISE is the command value zero-extended to AMBA_WORD.
- Command acceptance:
  - cmd_type, cmd_width, cmd_data and cmd_noise are registered on accept.
  - cmd_ready is 0 from the cycle after accept until the cycle after rsp_valid.
- cmd_type=0: no APB traffic; rsp_valid the cycle after accept with rsp_data=0, rsp_num_err=0, rsp_timeout=0.
- FSM: IDLE -> SETUP -> ACCESS -> (next register: SETUP | last: WAIT) -> RESP -> IDLE.
- Write order: DATA_IN, CODEWORD_WIDTH, NOISE, then CTRL. The CTRL write triggers the slave.
- SETUP: psel=1, penable=0, pwrite=1, paddr/pwdata valid.
- ACCESS: psel=1, penable=1. No pready exists, so each transfer completes in ACCESS.
- Each write is 2 cycles; 4 writes take 8 cycles, back-to-back with no idle between transfers.
- paddr, pwdata and pwrite hold stable from SETUP through ACCESS. Outside transfers psel=penable=0 and paddr/pwdata hold their last value.
- WAIT:
  - The timeout counter starts at 0 on WAIT entry and increments each cycle.
  - If operation_done=1, capture data_out and num_of_errors and go to RESP.
  - If the count reaches TIMEOUT_CYCLES-1 without operation_done, go to RESP with rsp_timeout=1 and rsp_data/rsp_num_err=0.
  - If operation_done and the final timeout cycle coincide, done wins: no timeout.
- operation_done outside WAIT is ignored.
- RESP: rsp_valid=1 for exactly one cycle; rsp_* hold until the next rsp_valid.
- Reset mid-transfer: psel/penable drop asynchronously; no response is issued.

Optional Feature:
- Macro: ECC_APB_READBACK_EN.
- Defined:
  - After the CTRL write, the driver reads back DATA_IN, CODEWORD_WIDTH and NOISE before WAIT.
  - Each read uses pwrite=0, SETUP then ACCESS; prdata is sampled in ACCESS.
  - Extra output readback_err (1 bit, reset 0), valid with rsp_valid: set if any prdata differs from the written value.
- Not defined: no reads are issued, pwrite is never 0 during a transfer, and the readback_err port is absent.

Test Plan:
- Encode: cmd_type=1, cmd_width=0, cmd_data=0x5A, cmd_noise=0 -> writes 0x04=0x5A, 0x08=0, 0x0C=0, 0x00=0 in 8 cycles; slave done after 5 cycles with data_out=0xB5 -> rsp_valid with rsp_data=0xB5, rsp_timeout=0.
- Full channel: cmd_type=3, cmd_noise=0x1 -> CTRL write data=2; slave returns num_of_errors=1 -> rsp_num_err=1.
- Timeout: TIMEOUT_CYCLES=16, operation_done never asserted -> rsp_valid exactly 16 cycles after WAIT entry, rsp_timeout=1, rsp_data=0.
- cmd_type=0 -> psel stays 0; rsp_valid one cycle after accept; cmd_ready back to 1 the following cycle.
- Reset asserted during the NOISE ACCESS cycle -> psel/penable=0 immediately, no rsp_valid, cmd_ready=1 after release; a fresh command runs normally.
- ECC_APB_READBACK_EN with a slave returning 0xFF for DATA_IN where 0x5A was written -> three reads after the CTRL write, readback_err=1 with rsp_valid.

Source files
------------

// File: rtl/ecc_apb_driver_if.sv
// Command/response, APB and slave-status bundle between ecc_apb_driver (master) and its environment.
// Build option ECC_APB_READBACK_EN adds the readback_err response bit.
interface ecc_apb_driver_if #(
    parameter int unsigned AMBA_ADDR_WIDTH = 32,
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned DATA_WIDTH      = 32
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_type;
    logic [1:0]                 cmd_width;
    logic [DATA_WIDTH-1:0]      cmd_data;
    logic [DATA_WIDTH-1:0]      cmd_noise;

    logic [AMBA_ADDR_WIDTH-1:0] paddr;
    logic [AMBA_WORD-1:0]       pwdata;
    logic                       psel;
    logic                       penable;
    logic                       pwrite;
    logic [AMBA_WORD-1:0]       prdata;

    logic                       operation_done;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [1:0]                 num_of_errors;

    logic                       rsp_valid;
    logic [DATA_WIDTH-1:0]      rsp_data;
    logic [1:0]                 rsp_num_err;
    logic                       rsp_timeout;
`ifdef ECC_APB_READBACK_EN
    logic                       readback_err;
`endif

    modport master (
        input  cmd_valid, cmd_type, cmd_width, cmd_data, cmd_noise,
        input  prdata, operation_done, data_out, num_of_errors,
        output cmd_ready, paddr, pwdata, psel, penable, pwrite,
        output rsp_valid, rsp_data, rsp_num_err, rsp_timeout
`ifdef ECC_APB_READBACK_EN
        , output readback_err
`endif
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_width, cmd_data, cmd_noise,
        output prdata, operation_done, data_out, num_of_errors,
        input  cmd_ready, paddr, pwdata, psel, penable, pwrite,
        input  rsp_valid, rsp_data, rsp_num_err, rsp_timeout
`ifdef ECC_APB_READBACK_EN
        , input readback_err
`endif
    );
endinterface

// File: rtl/ecc_apb_driver.sv
// APB initiator: one ECC operation per command (DATA_IN, CODEWORD_WIDTH, NOISE, CTRL writes, then wait for done).
// Build option ECC_APB_READBACK_EN reads back the three data registers after CTRL and flags differences.
module ecc_apb_driver #(
    parameter int unsigned AMBA_ADDR_WIDTH = 32,
    parameter int unsigned AMBA_WORD       = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    ecc_apb_driver_if.master bus
);
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef ECC_APB_READBACK_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t                     r_state;
    logic [2:0]                 r_idx;
    logic [1:0]                 r_type;
    logic [1:0]                 r_width;
    logic [DATA_WIDTH-1:0]      r_data;
    logic [DATA_WIDTH-1:0]      r_noise;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_cmd_ready;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic                       r_psel;
    logic                       r_penable;
    logic                       r_pwrite;
    logic                       r_rsp_valid;
    logic [DATA_WIDTH-1:0]      r_rsp_data;
    logic [1:0]                 r_rsp_num_err;
    logic                       r_rsp_timeout;
    logic [2:0]                 w_next_idx;
`ifdef ECC_APB_READBACK_EN
    logic                       r_rb_err;
    logic                       r_readback_err;
`else
    logic                       w_unused;
`endif

    // Transfer slots 0..3 write DATA_IN, CODEWORD_WIDTH, NOISE, CTRL; slots 4..6 read back slots 0..2.
    function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return AMBA_ADDR_WIDTH'(32'h04);
            2'd1:    return AMBA_ADDR_WIDTH'(32'h08);
            2'd2:    return AMBA_ADDR_WIDTH'(32'h0C);
            default: return AMBA_ADDR_WIDTH'(32'h00);
        endcase
    endfunction

    function automatic logic [AMBA_WORD-1:0] reg_wdata(input logic [1:0] idx, input logic [1:0] typ,
                                                       input logic [1:0] width,
                                                       input logic [DATA_WIDTH-1:0] data,
                                                       input logic [DATA_WIDTH-1:0] noise);
        case (idx)
            2'd0:    return AMBA_WORD'(data);
            2'd1:    return AMBA_WORD'(width);
            2'd2:    return AMBA_WORD'(noise);
            default: return AMBA_WORD'(typ - 2'd1);
        endcase
    endfunction

    assign w_next_idx = r_idx + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_type        <= '0;
            r_width       <= '0;
            r_data        <= '0;
            r_noise       <= '0;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b1;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_num_err <= '0;
            r_rsp_timeout <= 1'b0;
`ifdef ECC_APB_READBACK_EN
            r_rb_err       <= 1'b0;
            r_readback_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_type      <= bus.cmd_type;
                        r_width     <= bus.cmd_width;
                        r_data      <= bus.cmd_data;
                        r_noise     <= bus.cmd_noise;
                        r_cmd_ready <= 1'b0;
`ifdef ECC_APB_READBACK_EN
                        r_rb_err    <= 1'b0;
`endif
                        if (bus.cmd_type == 2'd0) begin
                            // Nothing to do: answer straight away with an empty response.
                            r_state       <= S_RESP;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_data    <= '0;
                            r_rsp_num_err <= '0;
                            r_rsp_timeout <= 1'b0;
`ifdef ECC_APB_READBACK_EN
                            r_readback_err <= 1'b0;
`endif
                        end else begin
                            r_state   <= S_SETUP;
                            r_idx     <= '0;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_pwrite  <= 1'b1;
                            r_paddr   <= reg_addr(2'd0);
                            r_pwdata  <= reg_wdata(2'd0, bus.cmd_type, bus.cmd_width,
                                                   bus.cmd_data, bus.cmd_noise);
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
`ifdef ECC_APB_READBACK_EN
                    if (r_idx[2] && (bus.prdata != reg_wdata(r_idx[1:0], r_type, r_width, r_data, r_noise))) begin
                        r_rb_err <= 1'b1;
                    end
`endif
                    r_penable <= 1'b0;
                    if (r_idx == LAST_IDX) begin
                        r_psel  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_idx    <= w_next_idx;
                        r_pwrite <= ~w_next_idx[2];
                        r_paddr  <= reg_addr(w_next_idx[1:0]);
                        if (!w_next_idx[2]) begin
                            r_pwdata <= reg_wdata(w_next_idx[1:0], r_type, r_width, r_data, r_noise);
                        end
                        r_state  <= S_SETUP;
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over the last timeout cycle.
                    if (bus.operation_done) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= bus.data_out;
                        r_rsp_num_err <= bus.num_of_errors;
                        r_rsp_timeout <= 1'b0;
`ifdef ECC_APB_READBACK_EN
                        r_readback_err <= r_rb_err;
`endif
                        r_state       <= S_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= '0;
                        r_rsp_num_err <= '0;
                        r_rsp_timeout <= 1'b1;
`ifdef ECC_APB_READBACK_EN
                        r_readback_err <= r_rb_err;
`endif
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_num_err = r_rsp_num_err;
    assign bus.rsp_timeout = r_rsp_timeout;
`ifdef ECC_APB_READBACK_EN
    assign bus.readback_err = r_readback_err;
`else
    assign w_unused = ^bus.prdata;
`endif
endmodule

// File: tb/tb_ecc_apb_driver.sv
// Self-checking bench for ecc_apb_driver: randomized commands against a transaction-level model.
module tb_ecc_apb_driver;
    localparam int TMO = 16;
`ifdef ECC_APB_READBACK_EN
    localparam int NX = 7;
`else
    localparam int NX = 4;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        int          setup_rel;
        logic        stable;
    } xfer_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    ecc_apb_driver_if #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32), .DATA_WIDTH(32)) bus ();

    ecc_apb_driver #(
        .AMBA_ADDR_WIDTH(32), .AMBA_WORD(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Slave register file: stores completed writes, answers reads (optionally corrupting DATA_IN).
    logic [31:0] sregs [4];
    bit          corrupt = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) sregs <= '{default: 32'h0};
        else if (bus.psel && bus.penable && bus.pwrite) sregs[bus.paddr[3:2]] <= bus.pwdata;
    end
    assign bus.prdata = (corrupt && bus.paddr == 32'h4) ? 32'hFF : sregs[bus.paddr[3:2]];

    // Observations of one command and the model's expectations for it.
    xfer_t       obs_x[$];
    xfer_t       exp_x[$];
    int          obs_bad, obs_psel, obs_rsp_rel, obs_rsp_cnt, obs_ready_busy;
    bit          obs_accepted, obs_rsp, obs_hold_ok;
    logic        obs_ready_after, obs_rto, obs_rb;
    logic [31:0] obs_rdata;
    logic [1:0]  obs_rnerr;
    int          exp_rsp_rel;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rnerr;
    logic        exp_rto, exp_rb;

    function automatic void build_model(input logic [1:0] t, input logic [1:0] w, input logic [31:0] d,
                                        input logic [31:0] nz, input int dly, input logic [31:0] dout,
                                        input logic [1:0] nerr);
        xfer_t x;
        logic [31:0] addrs[4];
        logic [31:0] vals[4];
        int wait_entry;
        exp_x.delete();
        exp_rb = 1'b0;
        if (t == 2'd0) begin
            exp_rsp_rel = 1; exp_rdata = 32'h0; exp_rnerr = 2'd0; exp_rto = 1'b0;
            return;
        end
        addrs = '{32'h4, 32'h8, 32'hC, 32'h0};
        vals  = '{d, 32'(w), nz, 32'(t) - 32'd1};
        for (int i = 0; i < NX; i++) begin
            x.addr = addrs[i % 4];
            x.data = vals[i % 4];
            x.wr   = (i < 4);
            x.setup_rel = 1 + 2 * i;
            x.stable = 1'b1;
            exp_x.push_back(x);
            if (i >= 4 && corrupt && x.addr == 32'h4 && x.data != 32'hFF) exp_rb = 1'b1;
        end
        wait_entry = 1 + 2 * NX;
        if (dly < TMO) begin
            exp_rsp_rel = wait_entry + dly + 1; exp_rdata = dout; exp_rnerr = nerr; exp_rto = 1'b0;
        end else begin
            exp_rsp_rel = wait_entry + TMO; exp_rdata = 32'h0; exp_rnerr = 2'd0; exp_rto = 1'b1;
        end
    endfunction

    // Drives one command, plays the slave's operation_done, and records what the DUT did.
    task automatic do_cmd(input logic [1:0] t, input logic [1:0] w, input logic [31:0] d, input logic [31:0] nz,
                          input int dly, input logic [31:0] dout, input logic [1:0] nerr, input bit noise_done);
        int last_acc, n_acc, p_rel, wk;
        bit pend, fin;
        logic [31:0] pa, pd;
        logic pw;
        xfer_t x;
        obs_x.delete();
        obs_bad = 0; obs_psel = 0; obs_rsp = 0; obs_rsp_rel = -1; obs_rsp_cnt = 0; obs_ready_busy = 0;
        obs_accepted = 0; obs_hold_ok = 1; obs_ready_after = 1'b0;
        obs_rdata = 32'hx; obs_rnerr = 2'bx; obs_rto = 1'bx; obs_rb = 1'b0;
        bus.data_out = dout; bus.num_of_errors = nerr;
        for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        if (bus.cmd_ready !== 1'b1) return;
        bus.cmd_valid = 1'b1; bus.cmd_type = t; bus.cmd_width = w; bus.cmd_data = d; bus.cmd_noise = nz;
        @(posedge clk);
        obs_accepted = 1;
        last_acc = -1; n_acc = 0; pend = 0; fin = 0; p_rel = -1; pa = '0; pd = '0; pw = 1'b0;
        for (int rel = 1; rel <= 200 && !fin; rel++) begin
            @(negedge clk);
            if (rel == 1) begin
                bus.cmd_valid = 1'b0; bus.cmd_type = 2'($urandom); bus.cmd_width = 2'($urandom);
                bus.cmd_data = $urandom; bus.cmd_noise = $urandom;
            end
            if (bus.psel) obs_psel++;
            if (bus.psel && !bus.penable) begin
                pend = 1; p_rel = rel; pa = bus.paddr; pd = bus.pwdata; pw = bus.pwrite;
            end else if (bus.psel && bus.penable) begin
                if (pend && p_rel == rel - 1) begin
                    x.addr = pa; x.data = pd; x.wr = pw; x.setup_rel = p_rel;
                    x.stable = (bus.paddr === pa && bus.pwdata === pd && bus.pwrite === pw);
                    obs_x.push_back(x);
                end else obs_bad++;
                pend = 0; n_acc++;
                if (n_acc == NX) last_acc = rel;
            end else if (bus.penable) obs_bad++;
            if (obs_rsp) begin
                obs_ready_after = bus.cmd_ready;
                if (bus.rsp_valid) obs_rsp_cnt++;
                obs_hold_ok = (bus.rsp_data === obs_rdata && bus.rsp_num_err === obs_rnerr && bus.rsp_timeout === obs_rto);
                fin = 1;
            end else begin
                if (bus.cmd_ready) obs_ready_busy++;
                if (bus.rsp_valid) begin
                    obs_rsp = 1; obs_rsp_rel = rel; obs_rsp_cnt = 1;
                    obs_rdata = bus.rsp_data; obs_rnerr = bus.rsp_num_err; obs_rto = bus.rsp_timeout;
`ifdef ECC_APB_READBACK_EN
                    obs_rb = bus.readback_err;
`endif
                end
            end
            wk = (last_acc >= 0) ? rel - last_acc - 1 : -1;
            bus.operation_done = (wk >= 0 && wk == dly) || (wk < 0 && noise_done && $urandom_range(0, 3) == 0);
        end
        bus.operation_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_apb_ctl got %b%b%b want 000", bus.psel, bus.penable, bus.pwrite); end
        n_cmp++; if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin n_fail++; $display("FAIL reset_apb_bus got %h/%h want 0/0", bus.paddr, bus.pwdata); end
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_timeout !== 1'b0 || bus.rsp_num_err !== 2'd0 || bus.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp got v%b t%b n%0d d%h want all 0", bus.rsp_valid, bus.rsp_timeout, bus.rsp_num_err, bus.rsp_data); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got ready%b psel%b want 1/0", bus.cmd_ready, bus.psel); end
    endtask

    task automatic test_encode();
        build_model(2'd1, 2'd0, 32'h5A, 32'h0, 5, 32'hB5, 2'd0);
        do_cmd(2'd1, 2'd0, 32'h5A, 32'h0, 5, 32'hB5, 2'd0, 1'b1);
        n_cmp++; if (obs_accepted !== 1'b1) begin n_fail++; $display("FAIL enc_accept got %b want 1", obs_accepted); end
        n_cmp++; if (obs_x.size() != exp_x.size()) begin n_fail++; $display("FAIL enc_xfer_count got %0d want %0d", obs_x.size(), exp_x.size()); end
        for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
            n_cmp++;
            if (obs_x[i].addr !== exp_x[i].addr || obs_x[i].wr !== exp_x[i].wr || obs_x[i].setup_rel != exp_x[i].setup_rel
                || obs_x[i].stable !== 1'b1 || (exp_x[i].wr && obs_x[i].data !== exp_x[i].data)) begin
                n_fail++; $display("FAIL enc_xfer%0d got a%h d%h w%b c%0d s%b want a%h d%h w%b c%0d s1", i, obs_x[i].addr, obs_x[i].data, obs_x[i].wr, obs_x[i].setup_rel, obs_x[i].stable, exp_x[i].addr, exp_x[i].data, exp_x[i].wr, exp_x[i].setup_rel);
            end
        end
        n_cmp++; if (obs_bad != 0) begin n_fail++; $display("FAIL enc_phase got %0d bad cycles want 0", obs_bad); end
        n_cmp++; if (obs_rsp_rel != exp_rsp_rel || obs_rsp_cnt != 1) begin n_fail++; $display("FAIL enc_rsp_time got cycle %0d x%0d want cycle %0d x1", obs_rsp_rel, obs_rsp_cnt, exp_rsp_rel); end
        n_cmp++; if (obs_rdata !== exp_rdata || obs_rnerr !== exp_rnerr || obs_rto !== exp_rto) begin n_fail++; $display("FAIL enc_rsp got d%h n%0d t%b want d%h n%0d t%b", obs_rdata, obs_rnerr, obs_rto, exp_rdata, exp_rnerr, exp_rto); end
        n_cmp++; if (obs_ready_busy != 0 || obs_ready_after !== 1'b1 || !obs_hold_ok) begin n_fail++; $display("FAIL enc_ready got busy%0d after%b hold%b want 0/1/1", obs_ready_busy, obs_ready_after, obs_hold_ok); end
    endtask

    task automatic test_full_channel();
        logic [31:0] d, dout;
        d = $urandom; dout = $urandom;
        build_model(2'd3, 2'd1, d, 32'h1, 3, dout, 2'd1);
        do_cmd(2'd3, 2'd1, d, 32'h1, 3, dout, 2'd1, 1'b0);
        n_cmp++; if (obs_x.size() < 4 || obs_x[3].addr !== 32'h0 || obs_x[3].data !== 32'h2) begin n_fail++; $display("FAIL full_ctrl_write got n%0d want CTRL=2 as 4th write", obs_x.size()); end
        n_cmp++; if (obs_x.size() < 3 || obs_x[2].data !== 32'h1 || obs_x[0].data !== d) begin n_fail++; $display("FAIL full_data_noise want DATA_IN=%h NOISE=1", d); end
        n_cmp++; if (obs_rnerr !== 2'd1 || obs_rdata !== dout || obs_rto !== 1'b0 || obs_rsp_rel != exp_rsp_rel) begin n_fail++; $display("FAIL full_rsp got n%0d d%h t%b c%0d want n1 d%h t0 c%0d", obs_rnerr, obs_rdata, obs_rto, obs_rsp_rel, dout, exp_rsp_rel); end
    endtask

    task automatic test_timeout();
        int dlys[3];
        dlys = '{1000, TMO - 1, TMO};
        foreach (dlys[k]) begin
            build_model(2'd2, 2'd2, 32'h33, 32'h0, dlys[k], 32'hDEADBEEF, 2'd2);
            do_cmd(2'd2, 2'd2, 32'h33, 32'h0, dlys[k], 32'hDEADBEEF, 2'd2, 1'b0);
            n_cmp++; if (obs_rsp_rel != exp_rsp_rel || obs_rsp_cnt != 1) begin n_fail++; $display("FAIL tmo%0d_time got cycle %0d x%0d want cycle %0d x1", dlys[k], obs_rsp_rel, obs_rsp_cnt, exp_rsp_rel); end
            n_cmp++; if (obs_rto !== exp_rto || obs_rdata !== exp_rdata || obs_rnerr !== exp_rnerr) begin n_fail++; $display("FAIL tmo%0d_rsp got t%b d%h n%0d want t%b d%h n%0d", dlys[k], obs_rto, obs_rdata, obs_rnerr, exp_rto, exp_rdata, exp_rnerr); end
        end
    endtask

    task automatic test_nop();
        build_model(2'd0, 2'd3, 32'h77, 32'h9, 0, 32'h1234, 2'd3);
        do_cmd(2'd0, 2'd3, 32'h77, 32'h9, 0, 32'h1234, 2'd3, 1'b1);
        n_cmp++; if (obs_psel != 0 || obs_x.size() != 0) begin n_fail++; $display("FAIL nop_no_apb got %0d psel cycles want 0", obs_psel); end
        n_cmp++; if (obs_rsp_rel != exp_rsp_rel || obs_rsp_cnt != 1) begin n_fail++; $display("FAIL nop_rsp_time got cycle %0d x%0d want cycle 1 x1", obs_rsp_rel, obs_rsp_cnt); end
        n_cmp++; if (obs_rdata !== 32'h0 || obs_rnerr !== 2'd0 || obs_rto !== 1'b0) begin n_fail++; $display("FAIL nop_rsp got d%h n%0d t%b want 0/0/0", obs_rdata, obs_rnerr, obs_rto); end
        n_cmp++; if (obs_ready_after !== 1'b1 || obs_ready_busy != 0) begin n_fail++; $display("FAIL nop_ready got after%b busy%0d want 1/0", obs_ready_after, obs_ready_busy); end
    endtask

`ifdef ECC_APB_READBACK_EN
    task automatic test_readback();
        corrupt = 1'b1;
        build_model(2'd1, 2'd0, 32'h5A, 32'h0, 2, 32'hB5, 2'd0);
        do_cmd(2'd1, 2'd0, 32'h5A, 32'h0, 2, 32'hB5, 2'd0, 1'b0);
        corrupt = 1'b0;
        n_cmp++; if (obs_x.size() != 7) begin n_fail++; $display("FAIL rb_count got %0d want 7", obs_x.size()); end
        for (int i = 4; i < obs_x.size() && i < 7; i++) begin
            n_cmp++; if (obs_x[i].wr !== 1'b0 || obs_x[i].addr !== exp_x[i].addr || obs_x[i].setup_rel != exp_x[i].setup_rel) begin n_fail++; $display("FAIL rb_read%0d got a%h w%b c%0d want a%h w0 c%0d", i, obs_x[i].addr, obs_x[i].wr, obs_x[i].setup_rel, exp_x[i].addr, exp_x[i].setup_rel); end
        end
        n_cmp++; if (obs_rb !== 1'b1 || obs_rsp_rel != exp_rsp_rel) begin n_fail++; $display("FAIL rb_err got %b c%0d want 1 c%0d", obs_rb, obs_rsp_rel, exp_rsp_rel); end
    endtask
`endif

    task automatic test_reset_mid();
        bit seen = 0;
        int rsp_seen = 0, psel_seen = 0;
        for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_type = 2'd1; bus.cmd_width = 2'd1; bus.cmd_data = 32'hAB; bus.cmd_noise = 32'h4;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.psel && bus.penable && bus.pwrite && bus.paddr == 32'hC) seen = 1;
            else @(negedge clk);
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL rmid_noise_access got none want NOISE ACCESS cycle"); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_async got psel%b pen%b ready%b want 0/0/1", bus.psel, bus.penable, bus.cmd_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_seen++;
            if (bus.psel) psel_seen++;
        end
        n_cmp++; if (rsp_seen != 0 || psel_seen != 0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_quiet got rsp%0d psel%0d ready%b want 0/0/1", rsp_seen, psel_seen, bus.cmd_ready); end
        build_model(2'd2, 2'd3, 32'h11, 32'h22, 4, 32'h5555, 2'd2);
        do_cmd(2'd2, 2'd3, 32'h11, 32'h22, 4, 32'h5555, 2'd2, 1'b0);
        n_cmp++; if (obs_x.size() != NX || obs_rsp_rel != exp_rsp_rel || obs_rdata !== exp_rdata || obs_rnerr !== exp_rnerr) begin n_fail++; $display("FAIL rmid_fresh got n%0d c%0d d%h e%0d want n%0d c%0d d%h e%0d", obs_x.size(), obs_rsp_rel, obs_rdata, obs_rnerr, NX, exp_rsp_rel, exp_rdata, exp_rnerr); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] t, w, nerr;
        logic [31:0] d, nz, dout;
        int dly;
        bit nd;
        for (int it = 0; it < 16; it++) begin
            t = 2'($urandom_range(0, 3)); w = 2'($urandom); d = $urandom; nz = $urandom; dout = $urandom;
            nerr = 2'($urandom); dly = $urandom_range(0, 20); nd = 1'($urandom);
            build_model(t, w, d, nz, dly, dout, nerr);
            do_cmd(t, w, d, nz, dly, dout, nerr, nd);
            n_cmp++; if (obs_x.size() != exp_x.size() || obs_bad != 0) begin n_fail++; $display("FAIL b2b%0d_xfers got n%0d bad%0d want n%0d bad0", it, obs_x.size(), obs_bad, exp_x.size()); end
            for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
                n_cmp++;
                if (obs_x[i].addr !== exp_x[i].addr || obs_x[i].wr !== exp_x[i].wr || obs_x[i].setup_rel != exp_x[i].setup_rel
                    || obs_x[i].stable !== 1'b1 || (exp_x[i].wr && obs_x[i].data !== exp_x[i].data)) begin
                    n_fail++; $display("FAIL b2b%0d_xfer%0d got a%h d%h w%b c%0d want a%h d%h w%b c%0d", it, i, obs_x[i].addr, obs_x[i].data, obs_x[i].wr, obs_x[i].setup_rel, exp_x[i].addr, exp_x[i].data, exp_x[i].wr, exp_x[i].setup_rel);
                end
            end
            n_cmp++; if (obs_rsp_rel != exp_rsp_rel || obs_rsp_cnt != 1 || obs_rdata !== exp_rdata || obs_rnerr !== exp_rnerr || obs_rto !== exp_rto) begin n_fail++; $display("FAIL b2b%0d_rsp got c%0d x%0d d%h n%0d t%b want c%0d x1 d%h n%0d t%b", it, obs_rsp_rel, obs_rsp_cnt, obs_rdata, obs_rnerr, obs_rto, exp_rsp_rel, exp_rdata, exp_rnerr, exp_rto); end
            n_cmp++; if (obs_ready_busy != 0 || obs_ready_after !== 1'b1 || !obs_hold_ok) begin n_fail++; $display("FAIL b2b%0d_ready got busy%0d after%b hold%b want 0/1/1", it, obs_ready_busy, obs_ready_after, obs_hold_ok); end
`ifdef ECC_APB_READBACK_EN
            n_cmp++; if (obs_rb !== exp_rb) begin n_fail++; $display("FAIL b2b%0d_rb got %b want %b", it, obs_rb, exp_rb); end
`endif
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_width = 2'd0; bus.cmd_data = 32'h0; bus.cmd_noise = 32'h0;
        bus.operation_done = 1'b0; bus.data_out = 32'h0; bus.num_of_errors = 2'd0;
        test_reset();
        test_encode();
        test_full_channel();
        test_timeout();
        test_nop();
`ifdef ECC_APB_READBACK_EN
        test_readback();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end
endmodule
